// File: rtl/loby_pkg.sv
// Shared constants, FSM encoding and payload types for the LoBy stream sequencer.
package loby_pkg;

  localparam int unsigned SIZE     = 257;
  localparam int unsigned SIZE_DIN = 64;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INIT,
    ST_GAP,
    ST_WAIT,
    ST_PULSE,
    ST_CAPT,
    ST_HOLD
  } state_t;

  // Attributes of the word currently in flight
  typedef struct packed {
    logic sqz;
    logic last;
  } word_attr_t;

  function automatic logic [SIZE_DIN-1:0] bitrev_din(input logic [SIZE_DIN-1:0] x);
    logic [SIZE_DIN-1:0] r;
    for (int i = 0; i < int'(SIZE_DIN); i++) r[i] = x[int'(SIZE_DIN) - 1 - i];
    return r;
  endfunction

endpackage

// File: rtl/loby_bitrev.sv
// Combinational optional bit-reversal of a WIDTH-bit vector.
module loby_bitrev #(
  parameter int unsigned WIDTH  = 8,
  parameter bit          ENABLE = 1'b1
) (
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] data_rev_c
);

  always_comb begin
    data_rev_c = data;
    if (ENABLE) begin
      for (int i = 0; i < int'(WIDTH); i++) data_rev_c[i] = data[int'(WIDTH) - 1 - i];
    end
  end

endmodule

// File: rtl/loby_stream_ctrl.sv
// Upstream sequencer for the LoBy sponge core: spaces init/absorb/squeeze pulses
// with idle gaps and returns each squeeze output on a valid/ready tag port.
module loby_stream_ctrl
  import loby_pkg::*;
#(
  parameter int unsigned GAP_CYCLES   = 2,
  parameter int unsigned DOUT_DELAY   = 1,
  parameter bit          REVERSE_BITS = 1'b1
) (
  input  logic                clk,
  input  logic                arstn,
  input  logic                start,
  input  logic [SIZE-1:0]     key_in,
  output logic                busy,
  input  logic                msg_valid,
  output logic                msg_ready,
  input  logic [SIZE_DIN-1:0] msg_data,
  input  logic                msg_sqz,
  input  logic                msg_last,
  output logic                core_init,
  output logic                core_sqz,
  output logic [SIZE_DIN-1:0] core_din,
  output logic                core_din_valid,
  output logic [SIZE-1:0]     core_key,
  input  logic [SIZE-1:0]     core_dout,
  output logic                tag_valid,
  input  logic                tag_ready,
  output logic [SIZE-1:0]     tag_data,
  output logic                tag_last
);

  localparam int unsigned CNT_MAX   = (GAP_CYCLES > DOUT_DELAY) ? GAP_CYCLES : DOUT_DELAY;
  localparam int unsigned CNT_W     = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX);
  localparam int unsigned GAP_LOAD  = GAP_CYCLES - 1;
  localparam int unsigned CAPT_LOAD = (DOUT_DELAY > 1) ? DOUT_DELAY - 2 : 0;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  word_attr_t         attr_q;
  logic               accept_c;
  logic               sample_c;
  logic               begin_c;
  logic [SIZE-1:0]    key_rev;
  logic [SIZE_DIN-1:0] din_rev;
  logic [SIZE-1:0]    dout_rev;

  loby_bitrev #(.WIDTH(SIZE),     .ENABLE(REVERSE_BITS)) u_rev_key  (.data(key_in),    .data_rev_c(key_rev));
  loby_bitrev #(.WIDTH(SIZE_DIN), .ENABLE(REVERSE_BITS)) u_rev_din  (.data(msg_data),  .data_rev_c(din_rev));
  loby_bitrev #(.WIDTH(SIZE),     .ENABLE(REVERSE_BITS)) u_rev_dout (.data(core_dout), .data_rev_c(dout_rev));

  assign begin_c  = (state_q == ST_IDLE) && start;
  assign accept_c = (state_q == ST_WAIT) && msg_valid;
  // dout is sampled DOUT_DELAY edges after the edge that launched the squeeze
  assign sample_c = ((state_q == ST_PULSE) && attr_q.sqz && (DOUT_DELAY == 1)) ||
                    ((state_q == ST_CAPT) && (cnt_q == '0));

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: if (start) state_d = ST_INIT;
      ST_INIT: begin
        state_d = ST_GAP;
        cnt_d   = CNT_W'(GAP_LOAD);
      end
      ST_GAP: begin
        if (cnt_q == '0) state_d = attr_q.last ? ST_IDLE : ST_WAIT;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      ST_WAIT: if (msg_valid) state_d = ST_PULSE;
      ST_PULSE: begin
        if (!attr_q.sqz) begin
          state_d = ST_GAP;
          cnt_d   = CNT_W'(GAP_LOAD);
        end else if (DOUT_DELAY == 1) begin
          state_d = ST_HOLD;
        end else begin
          state_d = ST_CAPT;
          cnt_d   = CNT_W'(CAPT_LOAD);
        end
      end
      ST_CAPT: begin
        if (cnt_q == '0) state_d = ST_HOLD;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      ST_HOLD: begin
        if (tag_ready) begin
          state_d = ST_GAP;
          cnt_d   = CNT_W'(GAP_LOAD);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Core-facing pins and handshakes, registered from the next state
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      busy           <= 1'b0;
      msg_ready      <= 1'b0;
      core_init      <= 1'b0;
      core_sqz       <= 1'b0;
      core_din_valid <= 1'b0;
      core_din       <= '0;
      core_key       <= '0;
      attr_q         <= '0;
    end else begin
      busy           <= (state_d != ST_IDLE);
      msg_ready      <= (state_d == ST_WAIT);
      core_init      <= begin_c;
      core_din_valid <= accept_c;
      core_sqz       <= accept_c && msg_sqz;
      if (begin_c) begin
        core_key <= key_rev;
        attr_q   <= '0;
      end
      if (accept_c) begin
        core_din    <= din_rev;
        attr_q.sqz  <= msg_sqz;
        attr_q.last <= msg_last;
      end
    end
  end

  // Tag register: filled on capture, released one cycle after the handshake
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      tag_valid <= 1'b0;
      tag_data  <= '0;
      tag_last  <= 1'b0;
    end else if (sample_c) begin
      tag_valid <= 1'b1;
      tag_data  <= dout_rev;
      tag_last  <= attr_q.last;
    end else if ((state_q == ST_HOLD) && tag_ready) begin
      tag_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_loby_stream_ctrl.sv
// Directed self-checking bench for loby_stream_ctrl with default parameters.
module tb_loby_stream_ctrl;
  import loby_pkg::*;

  logic                clk = 1'b0;
  logic                arstn;
  logic                start;
  logic [SIZE-1:0]     key_in;
  logic                busy;
  logic                msg_valid;
  logic                msg_ready;
  logic [SIZE_DIN-1:0] msg_data;
  logic                msg_sqz;
  logic                msg_last;
  logic                core_init;
  logic                core_sqz;
  logic [SIZE_DIN-1:0] core_din;
  logic                core_din_valid;
  logic [SIZE-1:0]     core_key;
  logic [SIZE-1:0]     core_dout;
  logic                tag_valid;
  logic                tag_ready;
  logic [SIZE-1:0]     tag_data;
  logic                tag_last;

  int checks = 0;
  int errors = 0;

  loby_stream_ctrl dut (
    .clk(clk), .arstn(arstn), .start(start), .key_in(key_in), .busy(busy),
    .msg_valid(msg_valid), .msg_ready(msg_ready), .msg_data(msg_data),
    .msg_sqz(msg_sqz), .msg_last(msg_last), .core_init(core_init),
    .core_sqz(core_sqz), .core_din(core_din), .core_din_valid(core_din_valid),
    .core_key(core_key), .core_dout(core_dout), .tag_valid(tag_valid),
    .tag_ready(tag_ready), .tag_data(tag_data), .tag_last(tag_last)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Stimulus: pulse start for one cycle with the given key
  task automatic do_start(input logic [SIZE-1:0] key);
    start  = 1'b1;
    key_in = key;
    cyc();
    start  = 1'b0;
  endtask

  // Stimulus: wait (bounded) until msg_ready is observed
  task automatic wait_ready(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (msg_ready) begin
        ok = 1'b1;
        break;
      end
      cyc();
    end
  endtask

  task automatic test_reset();
    bit ok;
    arstn = 1'b0; start = 0; key_in = '0; msg_valid = 0; msg_data = '0;
    msg_sqz = 0; msg_last = 0; tag_ready = 0; core_dout = '0;
    cyc(); cyc();
    checks++;
    if ({busy, msg_ready, core_init, core_sqz, core_din_valid, tag_valid, tag_last} !== 7'b0) begin
      errors++; $display("FAIL reset_ctl got %b want 0000000",
        {busy, msg_ready, core_init, core_sqz, core_din_valid, tag_valid, tag_last});
    end
    arstn = 1'b1;
    cyc();
    do_start(257'h7);
    wait_ready(ok);
    msg_valid = 1; msg_data = 64'hFF; msg_sqz = 1; msg_last = 0;
    cyc();
    msg_valid = 0;
    checks++;
    if (core_din_valid !== 1'b1) begin
      errors++; $display("FAIL reset_setup_pulse got %b want 1", core_din_valid);
    end
    arstn = 1'b0;
    #1;
    checks++;
    if ({busy, msg_ready, core_init, core_sqz, core_din_valid, tag_valid, tag_last} !== 7'b0 ||
        core_din !== '0 || core_key !== '0 || tag_data !== '0) begin
      errors++; $display("FAIL reset_async got ctl=%b din=%h want all zero",
        {busy, msg_ready, core_init, core_sqz, core_din_valid, tag_valid, tag_last}, core_din);
    end
    core_dout = 257'h1234;
    cyc();
    arstn = 1'b1;
    ok = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cyc();
      if (tag_valid !== 1'b0 || busy !== 1'b0) ok = 1'b0;
    end
    checks++;
    if (!ok) begin
      errors++; $display("FAIL reset_quiet got busy=%b tag_valid=%b want 0 0", busy, tag_valid);
    end
    core_dout = '0;
  endtask

  task automatic test_start();
    int first;
    start = 1'b1; key_in = 257'h1;
    cyc();
    start = 1'b0;
    checks++;
    if (core_init !== 1'b1) begin
      errors++; $display("FAIL start_init_hi got %b want 1", core_init);
    end
    checks++;
    if (core_key !== (257'h1 << 256)) begin
      errors++; $display("FAIL start_key got %h want %h", core_key, 257'h1 << 256);
    end
    first = -1;
    for (int i = 2; i <= 6; i++) begin
      cyc();
      if (i == 2) begin
        checks++;
        if (core_init !== 1'b0) begin
          errors++; $display("FAIL start_init_len got %b want 0", core_init);
        end
      end
      if (msg_ready === 1'b1 && first < 0) first = i;
      if (i == 4) break;
    end
    checks++;
    if (first !== 4) begin
      errors++; $display("FAIL start_ready_latency got %0d want 4", first);
    end
  endtask

  task automatic test_absorb();
    logic [SIZE_DIN-1:0] words [2];
    logic [SIZE_DIN-1:0] seen_din [2];
    int pulse_at [2];
    int np, w;
    bit acc, sqz_bad;
    words[0] = 64'h1; words[1] = 64'h2;
    np = 0; w = 0; sqz_bad = 0;
    msg_valid = 1; msg_data = words[0]; msg_sqz = 0; msg_last = 0;
    for (int i = 1; i <= 8; i++) begin
      acc = msg_ready && msg_valid;
      cyc();
      if (acc) begin
        w++;
        if (w < 2) msg_data = words[w];
        else msg_valid = 0;
      end
      if (core_din_valid === 1'b1) begin
        if (np < 2) begin
          seen_din[np] = core_din;
          pulse_at[np] = i;
        end
        if (core_sqz !== 1'b0) sqz_bad = 1;
        np++;
      end
    end
    checks++;
    if (np !== 2) begin
      errors++; $display("FAIL absorb_count got %0d want 2", np);
    end else begin
      checks++;
      if (seen_din[0] !== 64'h8000_0000_0000_0000 || seen_din[1] !== 64'h4000_0000_0000_0000) begin
        errors++; $display("FAIL absorb_din got %h %h want 8000000000000000 4000000000000000",
          seen_din[0], seen_din[1]);
      end
      checks++;
      if (pulse_at[1] - pulse_at[0] !== 4) begin
        errors++; $display("FAIL absorb_pitch got %0d want 4", pulse_at[1] - pulse_at[0]);
      end
    end
    checks++;
    if (sqz_bad) begin
      errors++; $display("FAIL absorb_sqz got 1 want 0");
    end
  endtask

  task automatic test_squeeze_last();
    int n;
    checks++;
    if (msg_ready !== 1'b1) begin
      errors++; $display("FAIL sqz_ready_pre got %b want 1", msg_ready);
    end
    core_dout = 257'h3;
    msg_valid = 1; msg_data = 64'hAB; msg_sqz = 1; msg_last = 1;
    cyc();
    msg_valid = 0;
    checks++;
    if ({core_din_valid, core_sqz} !== 2'b11) begin
      errors++; $display("FAIL sqz_pulse got %b want 11", {core_din_valid, core_sqz});
    end
    cyc();
    checks++;
    if ({core_din_valid, core_sqz, tag_valid, tag_last} !== 4'b0011 || tag_data !== (257'h3 << 255)) begin
      errors++; $display("FAIL sqz_tag got ctl=%b data=%h want 0011 %h",
        {core_din_valid, core_sqz, tag_valid, tag_last}, tag_data, 257'h3 << 255);
    end
    tag_ready = 1;
    cyc();
    tag_ready = 0;
    checks++;
    if (tag_valid !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL sqz_handshake got tag_valid=%b busy=%b want 0 1", tag_valid, busy);
    end
    n = 1;
    while (busy === 1'b1 && n < 10) begin
      cyc();
      n++;
    end
    checks++;
    if (n !== 3) begin
      errors++; $display("FAIL sqz_to_idle got %0d want 3", n);
    end
  endtask

  task automatic test_backpressure();
    bit ok, stable;
    logic [SIZE-1:0] held;
    int n;
    do_start(257'h5);
    wait_ready(ok);
    core_dout = 257'h1;
    msg_valid = 1; msg_data = 64'h10; msg_sqz = 1; msg_last = 0;
    cyc();
    msg_data = 64'h20; msg_sqz = 0; msg_last = 1;
    cyc();
    held = tag_data;
    checks++;
    if (tag_valid !== 1'b1 || held !== (257'h1 << 256)) begin
      errors++; $display("FAIL bp_tag got v=%b d=%h want 1 %h", tag_valid, held, 257'h1 << 256);
    end
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      core_dout = SIZE'(i + 100);
      cyc();
      if (msg_ready !== 1'b0 || tag_valid !== 1'b1 || tag_data !== held || core_din_valid !== 1'b0)
        stable = 1'b0;
    end
    checks++;
    if (!stable) begin
      errors++; $display("FAIL bp_hold got ready=%b tag_valid=%b want 0 1 and stable data", msg_ready, tag_valid);
    end
    tag_ready = 1;
    n = 0;
    while (msg_ready !== 1'b1 && n < 20) begin
      cyc();
      tag_ready = 0;
      n++;
    end
    checks++;
    if (n !== 3) begin
      errors++; $display("FAIL bp_accept_latency got %0d want 3", n);
    end
    cyc();
    msg_valid = 0;
    checks++;
    if (core_din_valid !== 1'b1 || core_din !== 64'h0400_0000_0000_0000) begin
      errors++; $display("FAIL bp_word got v=%b din=%h want 1 0400000000000000", core_din_valid, core_din);
    end
    n = 0;
    while (busy === 1'b1 && n < 20) begin
      cyc();
      n++;
    end
    checks++;
    if (busy !== 1'b0 || tag_valid !== 1'b0) begin
      errors++; $display("FAIL bp_end got busy=%b tag_valid=%b want 0 0", busy, tag_valid);
    end
  endtask

  task automatic test_vectors();
    logic [SIZE-1:0]     v_key  [2];
    logic [SIZE-1:0]     v_kexp [2];
    logic [SIZE_DIN-1:0] v_abs  [2][2];
    logic [SIZE-1:0]     v_dout [2][2];
    logic [SIZE-1:0]     v_exp  [2][2];
    logic [SIZE-1:0]     got [2];
    logic                got_last;
    int ntag, w, nsq, guard;
    bit acc, take;
    v_key[0] = 257'h1; v_kexp[0] = 257'h1 << 256;
    v_key[1] = 257'h2; v_kexp[1] = 257'h1 << 255;
    v_abs[0][0] = 64'h1; v_abs[0][1] = 64'h2;
    v_abs[1][0] = 64'h3; v_abs[1][1] = 64'h4;
    v_dout[0][0] = 257'h5;          v_exp[0][0] = 257'h5 << 254;
    v_dout[0][1] = 257'hF;          v_exp[0][1] = 257'hF << 253;
    v_dout[1][0] = 257'h1 << 256;   v_exp[1][0] = 257'h1;
    v_dout[1][1] = 257'h3 << 100;   v_exp[1][1] = 257'h3 << 155;
    for (int v = 0; v < 2; v++) begin
      w = 0; nsq = 0; ntag = 0; got_last = 0; guard = 0; take = 0;
      got[0] = '0; got[1] = '0;
      msg_valid = 1; msg_data = v_abs[v][0]; msg_sqz = 0; msg_last = 0;
      do_start(v_key[v]);
      checks++;
      if (core_key !== v_kexp[v]) begin
        errors++; $display("FAIL vec%0d_key got %h want %h", v, core_key, v_kexp[v]);
      end
      while ((busy === 1'b1 || w < 4) && guard < 200) begin
        acc = msg_ready && msg_valid;
        cyc();
        guard++;
        if (take) begin
          if (ntag < 2) got[ntag] = tag_data;
          got_last = tag_last;
          ntag++;
          tag_ready = 0;
          take = 0;
          cyc();
          guard++;
        end
        if (acc) begin
          w++;
          msg_data = (w < 2) ? v_abs[v][w] : SIZE_DIN'(w);
          msg_sqz  = (w >= 2);
          msg_last = (w == 3);
          if (w >= 4) msg_valid = 0;
        end
        if (core_din_valid && core_sqz) begin
          if (nsq < 2) core_dout = v_dout[v][nsq];
          nsq++;
        end
        if (tag_valid) begin
          take = 1;
          tag_ready = 1;
          if (ntag < 2) got[ntag] = tag_data;
        end
      end
      msg_valid = 0;
      checks++;
      if (ntag !== 2 || got_last !== 1'b1) begin
        errors++; $display("FAIL vec%0d_tags got n=%0d last=%b want 2 1", v, ntag, got_last);
      end
      checks++;
      if (got[0] !== v_exp[v][0] || got[1] !== v_exp[v][1]) begin
        errors++; $display("FAIL vec%0d_tag got %h %h want %h %h", v, got[0], got[1], v_exp[v][0], v_exp[v][1]);
      end
      cyc();
    end
  endtask

  initial begin
    test_reset();
    test_start();
    test_absorb();
    test_squeeze_last();
    test_backpressure();
    test_vectors();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got running want finished");
    $fatal(1);
  end

endmodule
